// File: rtl/uart_rx_checked.sv
// UART receiver with 16x-style oversampling, optional parity and stop-bit checks,
// valid/ready holding register, overrun and break detection.
module uart_rx_checked #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       break_det
);

  localparam int unsigned DIV_RAW = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DCNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TCNT_W  = $clog2(OVERSAMPLE);

  localparam logic [DCNT_W-1:0] DIV_M1  = DCNT_W'(DIV - 1);
  localparam logic [TCNT_W-1:0] HALF_M1 = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] FULL_M1 = TCNT_W'(OVERSAMPLE - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              par_bit_q, par_bit_d;
  logic              stop0_q, stop0_d;
  logic              stop_idx_q, stop_idx_d;
  logic              done_q, done_d;
  logic              done_brk_q, done_brk_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              break_det_q, break_det_d;

  logic rxs, tick, start_edge, par_calc, stop0_now, brk_now;

  assign rxs  = sync_q[1];
  assign tick = (dcnt_q == DIV_M1);

  // Receive FSM, tick divider and synchronizer next-state
  always_comb begin
    sync_d     = {sync_q[0], RxD};
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    par_bit_d  = par_bit_q;
    stop0_d    = stop0_q;
    stop_idx_d = stop_idx_q;
    done_d     = 1'b0;
    done_brk_d = 1'b0;
    start_edge = 1'b0;
    par_calc   = (^shift_q) ^ rxs;
    stop0_now  = (stop_idx_q == 1'b0) ? rxs : stop0_q;
    brk_now    = (shift_q == 8'h00) && !par_bit_q && !stop0_now;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d    = S_START;
          start_edge = 1'b1;
          tcnt_d     = '0;
          bit_idx_d  = 3'd0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          par_bit_d  = 1'b0;
          stop0_d    = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt_q == HALF_M1) begin
            tcnt_d = '0;
            if (rxs) begin
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              bit_idx_d = 3'd0;
            end
          end else begin
            tcnt_d = TCNT_W'(tcnt_q + 1'b1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt_q == FULL_M1) begin
            tcnt_d    = '0;
            shift_d   = {rxs, shift_q[7:1]};
            bit_idx_d = 3'(bit_idx_q + 3'd1);
            if (bit_idx_q == 3'd7) begin
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            tcnt_d = TCNT_W'(tcnt_q + 1'b1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (tcnt_q == FULL_M1) begin
            tcnt_d    = '0;
            par_bit_d = rxs;
            perr_d    = (PARITY == 1) ? par_calc : ~par_calc;
            state_d   = S_STOP;
          end else begin
            tcnt_d = TCNT_W'(tcnt_q + 1'b1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tcnt_q == FULL_M1) begin
            tcnt_d     = '0;
            ferr_d     = ferr_q | ~rxs;
            stop0_d    = stop0_now;
            stop_idx_d = ~stop_idx_q;
            if (stop_idx_q == LAST_STOP) begin
              done_d     = 1'b1;
              done_brk_d = brk_now;
              state_d    = brk_now ? S_BRKWAIT : S_IDLE;
            end
          end else begin
            tcnt_d = TCNT_W'(tcnt_q + 1'b1);
          end
        end
      end
      S_BRKWAIT: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_edge || tick) dcnt_d = '0;
    else                    dcnt_d = DCNT_W'(dcnt_q + 1'b1);
  end

  // Holding register: completion is resolved one clk after the final stop sample
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    break_det_d  = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (done_q) begin
      if (done_brk_q) begin
        break_det_d = 1'b1;
      end else if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      dcnt_q       <= '0;
      tcnt_q       <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      par_bit_q    <= 1'b0;
      stop0_q      <= 1'b1;
      stop_idx_q   <= 1'b0;
      done_q       <= 1'b0;
      done_brk_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      dcnt_q       <= dcnt_d;
      tcnt_q       <= tcnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      par_bit_q    <= par_bit_d;
      stop0_q      <= stop0_d;
      stop_idx_q   <= stop_idx_d;
      done_q       <= done_d;
      done_brk_q   <= done_brk_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      break_det_q  <= break_det_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_det_q;

endmodule

// File: tb/tb_uart_rx_checked.sv
// Scoreboard bench for uart_rx_checked: three configurations (no parity,
// even parity, two stop bits), one driven at a time through a selector.
module tb_uart_rx_checked;

  localparam int unsigned BIT_CLKS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_ready = 1'b1;
  logic rxd0 = 1'b1, rxd1 = 1'b1, rxd2 = 1'b1;
  int   sel = 0;

  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, bk0, bk1, bk2;
  logic [7:0] m_data;
  logic m_valid, m_pe, m_fe, m_ov, m_bk;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0, brk_cnt = 0, vrise = 0;
  logic prev_v = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  uart_rx_checked #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .rst(rst), .RxD(rxd0), .rx_data(d0), .rx_valid(v0), .rx_ready(rx_ready),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .break_det(bk0));
  uart_rx_checked #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u_p1 (
    .clk(clk), .rst(rst), .RxD(rxd1), .rx_data(d1), .rx_valid(v1), .rx_ready(rx_ready),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .break_det(bk1));
  uart_rx_checked #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) u_s2 (
    .clk(clk), .rst(rst), .RxD(rxd2), .rx_data(d2), .rx_valid(v2), .rx_ready(rx_ready),
    .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .break_det(bk2));

  always_comb begin
    case (sel)
      1:       begin m_data = d1; m_valid = v1; m_pe = pe1; m_fe = fe1; m_ov = ov1; m_bk = bk1; end
      2:       begin m_data = d2; m_valid = v2; m_pe = pe2; m_fe = fe2; m_ov = ov2; m_bk = bk2; end
      default: begin m_data = d0; m_valid = v0; m_pe = pe0; m_fe = fe0; m_ov = ov0; m_bk = bk0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output side of the scoreboard: pop on every accepted byte
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && !prev_v) vrise++;
      prev_v = m_valid;
      if (m_ov) ovr_cnt++;
      if (m_bk) brk_cnt++;
      if (m_valid && rx_ready) begin
        exp_t e;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rx_data", 32'(m_data), 32'(e.d));
          check("parity_err", 32'(m_pe), 32'(e.pe));
          check("frame_err", 32'(m_fe), 32'(e.fe));
        end
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic set_line(input logic v);
    rxd0 = (sel == 0) ? v : 1'b1;
    rxd1 = (sel == 1) ? v : 1'b1;
    rxd2 = (sel == 2) ? v : 1'b1;
  endtask

  task automatic hold_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pmode: 0 none, 1 even, 2 odd; push=0 when no byte is expected to be accepted
  task automatic send_frame(input logic [7:0] d, input int pmode, input logic p,
                            input logic s1, input logic s2, input bit two, input bit push);
    exp_t e;
    logic x;
    x = (^d) ^ p;
    e.d  = d;
    e.pe = (pmode == 1) ? x : (pmode == 2) ? ~x : 1'b0;
    e.fe = !s1 || (two && !s2);
    if (push && !(d == 8'h00 && (pmode == 0 || !p) && !s1)) sb.push_back(e);
    set_line(1'b0); hold_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      set_line(d[i]); hold_clks(BIT_CLKS);
    end
    if (pmode != 0) begin set_line(p); hold_clks(BIT_CLKS); end
    set_line(s1); hold_clks(BIT_CLKS);
    if (two) begin set_line(s2); hold_clks(BIT_CLKS); end
    set_line(1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk); n++;
    end
    hold_clks(4);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(d0), 32'd0);
    check({tag, "_valid"}, 32'(v0), 32'd0);
    check({tag, "_perr"}, 32'(pe0), 32'd0);
    check({tag, "_ferr"}, 32'(fe0), 32'd0);
    check({tag, "_ovr"}, 32'(ov0), 32'd0);
    check({tag, "_brk"}, 32'(bk0), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, vr0, ov_before, bk_before;
    hold_clks(3);
    check_reset_outputs("rst");
    check("rst_valid1", 32'(v1), 32'd0);
    check("rst_valid2", 32'(v2), 32'd0);
    rst = 1'b0;
    hold_clks(5);

    // Clean byte, no parity, with latency bound from the nominal stop midpoint
    sel = 0; rx_ready = 1'b1;
    lat = 0;
    fork
      send_frame(8'hA5, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      begin
        while (!v0 && lat < 400) begin
          @(posedge clk); #1; lat++;
        end
      end
    join
    check("a5_latency_ok", 32'(lat >= 152 && lat <= 162), 32'd1);
    hold_clks(2);
    check("a5_one_cycle", 32'(v0), 32'd0);
    wait_drain();

    // Even parity: wrong then correct parity bit
    sel = 1;
    send_frame(8'h03, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h03, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Backpressure and overrun
    sel = 0;
    @(posedge clk); #1; rx_ready = 1'b0;
    ov_before = ovr_cnt;
    send_frame(8'h11, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    hold_clks(10);
    check("ovr_pulses", 32'(ovr_cnt - ov_before), 32'd1);
    check("ovr_held_data", 32'(d0), 32'h11);
    check("ovr_held_valid", 32'(v0), 32'd1);
    rx_ready = 1'b1;
    hold_clks(2);
    check("ovr_drained", 32'(v0), 32'd0);
    wait_drain();

    // Break: 20 bit times low
    bk_before = brk_cnt; vr0 = vrise;
    set_line(1'b0); hold_clks(20 * BIT_CLKS);
    set_line(1'b1); hold_clks(2 * BIT_CLKS);
    check("brk_pulses", 32'(brk_cnt - bk_before), 32'd1);
    check("brk_no_valid", 32'(vrise - vr0), 32'd0);
    send_frame(8'h5A, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Short glitch on idle line
    vr0 = vrise;
    set_line(1'b0); hold_clks(5);
    set_line(1'b1); hold_clks(40);
    check("glitch_no_valid", 32'(vrise - vr0), 32'd0);
    check("glitch_idle", 32'(u_p0.state_q), 32'd0);

    // Two stop bits, second one low
    sel = 2;
    send_frame(8'h7E, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // Reset mid-byte while a byte is held
    sel = 0;
    rx_ready = 1'b0;
    send_frame(8'h3C, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    hold_clks(4);
    check("pre_rst_valid", 32'(v0), 32'd1);
    check("pre_rst_data", 32'(d0), 32'h3C);
    set_line(1'b0); hold_clks(BIT_CLKS);
    set_line(1'b1); hold_clks(BIT_CLKS);
    set_line(1'b0); hold_clks(10);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    set_line(1'b1);
    hold_clks(3);
    rst = 1'b0;
    rx_ready = 1'b1;
    hold_clks(5);
    send_frame(8'hC3, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_checked.md
Name: uart_rx_checked

Overview:
- Standalone UART receiver with 16x oversampling, optional parity and stop-bit checking.
- Delivers each byte through a valid/ready holding register, with per-byte error flags, overrun and break detection.
- Sits on the RxD pin as the receive counterpart to the team's 2-stop-bit UART transmitter.
- Feeds command/packet logic that may stall, so it adds backpressure handling.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; must be even and at least 8.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, number of stop bits checked: 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- RxD  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  8  received byte, valid while rx_valid=1
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts rx_data when rx_valid&rx_ready
- parity_err  out  1  parity mismatch for the held byte; meaningful only while rx_valid
- frame_err  out  1  a checked stop bit sampled 0 for the held byte; meaningful only while rx_valid
- overrun  out  1  one-cycle pulse: a byte completed while the register was full and not being drained
- break_det  out  1  one-cycle pulse: break condition detected

Behaviour:
- Reset is asynchronous and active-high on one clock, clk. All registers clear on rst=1.
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, break_det=0, synchronizer=2'b11, state=IDLE.
- Reset mid-frame abandons the frame; no byte and no flag are produced.
- Tick generator:
  - DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), minimum 1.
  - Counter 0..DIV-1; tick is asserted when the count equals DIV-1.
  - Counter is forced to 0 on start-edge detection in IDLE.
- RxD passes through a 2-flop synchronizer clocked every clk; rxs is its output.
- FSM states are IDLE, START, DATA, PARITY, STOP, BRKWAIT.
- Tick counting (tcnt) in all states except IDLE and BRKWAIT: it increments per tick, and every sample resets tcnt to 0.
- IDLE:
  - rxs=0 goes to START with tcnt=0.
- START:
  - At tcnt=OVERSAMPLE/2-1 on a tick, sample rxs (mid start bit).
  - rxs=1 is a glitch: return to IDLE with no output.
  - rxs=0 goes to DATA with bit index 0.
- DATA:
  - Sample on the tick where tcnt=OVERSAMPLE-1.
  - Shift in LSB first.
  - After bit 7, go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - Sample p.
  - Error if even mode and ^data^p=1, or odd mode and ^data^p=0.
- STOP:
  - Sample STOP_BITS times at OVERSAMPLE spacing.
  - Any 0 sets frame error.
  - After the last stop sample, complete the frame and return to IDLE, or BRKWAIT on break.
- Break: data=0, parity bit 0 (if present) and first stop bit 0.
  - Pulse break_det one cycle.
  - Deliver no byte; rx_valid and rx_data are unchanged.
  - Enter BRKWAIT, which returns to IDLE only after rxs=1.
- Completion, which occurs on the clk after the final stop sample:
  - rx_valid=0, or rx_valid=1 and rx_ready=1 in that same cycle: load rx_data and both error flags, and rx_valid=1. No overrun.
  - rx_valid=1 and rx_ready=0: keep the old byte and flags, pulse overrun one cycle, discard the new byte.
- Handshake:
  - rx_valid&rx_ready with no simultaneous completion clears rx_valid next cycle.
  - rx_data, parity_err and frame_err hold their values until the next load.
- A frame-error byte is still delivered, with frame_err=1.
- The receiver re-arms immediately in IDLE, so a start bit directly after the stop sample is caught.

Test Plan:
- Setup for all scenarios: CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16, so DIV=1 and one bit lasts 16 clk.
- Send 0xA5 with PARITY=0 and rx_ready=1 held -> one-cycle rx_valid with rx_data=0xA5, both error flags 0. rx_valid rises at most 8+2 clk after the nominal stop-bit midpoint.
- PARITY=1, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1. Then send 0x03 with parity bit 0 -> parity_err=0.
- Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses exactly once at the 0x22 completion. Raising rx_ready then clears rx_valid.
- Drive RxD low for 20 bit times, then high -> break_det pulses once and rx_valid stays 0. Then send 0x5A -> rx_data=0x5A.
- Apply a 5-clk low glitch on idle RxD -> no rx_valid, FSM back in IDLE.
- STOP_BITS=2, send 0x7E with second stop bit 0 -> rx_data=0x7E, frame_err=1.
- Assert rst mid-byte -> all outputs return to their reset values immediately. A following clean 0xC3 is received correctly.
